swg_phase_ctrl: RTL and testbench
=================================

// Module: swg_phase_ctrl
// PURPOSE
//  Sequencer for the 64-entry sine LUT datapath (SWG_design). Runs a phase accumulator, drives the LUT
//  index port T, registers the returned 16-bit sample and delivers it on a valid/ready stream.
//  Accepts frequency/phase/burst-length configuration through a handshake. Supports burst or
//  continuous runs, stop and backpressure. Sits between the register/config side and the
//  downstream consumer (DAC formatter).
// PARAMETERS
//  PHASE_W   16  phase accumulator width; wraps mod 2**PHASE_W
//  IDX_W     6   LUT index bits = acc[PHASE_W-1 -: IDX_W] (64 entries)
//  T_W       10  width of the LUT index port; index is zero-extended into it
//  SAMPLE_W  16  sample width
//  CNT_W     16  burst-count width
// PORTS
//  clk        in   1         single clock; all state on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  cfg_valid  in   1         config offer
//  cfg_ready  out  1         =1 only in IDLE (also while reset is held)
//  cfg_ftw    in   PHASE_W   frequency tuning word (phase step per sample)
//  cfg_phase0 in   PHASE_W   start phase
//  cfg_count  in   CNT_W     samples per burst; 0 = continuous
//  start      in   1         level-sampled; acted on only in IDLE
//  stop       in   1         level-sampled; acted on only in RUN
//  lut_t      out  T_W       to LUT T; combinational from acc register
//  lut_o      in   SAMPLE_W  from LUT O; combinational, same cycle
//  smp_valid  out  1         sample available
//  smp_ready  in   1         consumer accepts
//  smp_data   out  SAMPLE_W  registered sample
//  smp_last   out  1         final sample of a counted burst
//  busy       out  1         state != IDLE
//  done       out  1         one-cycle pulse on the return to IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, cnt=0, smp_valid=0, smp_data=0, smp_last=0, done=0.
//   Config regs reset to ftw=1<<(PHASE_W-IDX_W), phase0=0, count=0. Outputs: lut_t=0, busy=0, cfg_ready=1.
//   rst_n low mid-run clears all of the above immediately. The partial burst is lost.
//  Config: on cfg_valid&&cfg_ready, latch ftw/phase0/count. Offers made outside IDLE are not accepted.
//  States:
//   IDLE -start-> RUN: acc<=phase0, cnt<=count. If cfg handshake and start occur in the same
//    cycle, the newly offered values are used (bypass).
//   RUN: issue when !smp_valid || smp_ready, and stop=0.
//    Issue: smp_data<=lut_o, smp_valid<=1, acc<=acc+ftw (wrap). For count!=0: cnt<=cnt-1,
//     and smp_last<=(cnt==1).
//    After the issue with cnt==1: go to FLUSH.
//    stop=1: no issue in that cycle or later; go to FLUSH. smp_last is not forced.
//   FLUSH: wait until the output register is empty (or accepted this cycle), then go to IDLE and pulse done.
//  Hold: while smp_valid && !smp_ready, smp_data, smp_last and acc are frozen.
//   No sample is dropped or duplicated.
//  Latency: start sampled at edge E; acc valid after E; first smp_valid at edge E+1.
//   Sustained throughput is 1 sample/clk with smp_ready=1.
//  A sample is consumed on smp_valid&&smp_ready; smp_valid falls the next cycle unless a new issue occurs.
//  ftw=0 gives a constant sample. count=0 runs until stop; smp_last is never set.
//  cnt never underflows. start and stop are ignored in states other than those listed.
// STRUCTURE
//  swg_pkg: state enum {IDLE,RUN,FLUSH}; LUT_DEPTH=64; DEFAULT_FTW; index-extraction function.
//  Sub-module swg_phase_acc: load/advance/hold accumulator plus index extraction into lut_t.
//  FSM, counter and output register live in the top.
//  The LUT (SWG_design) is instantiated by the parent, not inside this block.
// TESTING
//  1 Reset, then start with default cfg, smp_ready=1 -> first sample 1000 one edge after start,
//    then 1098,1195,1290; sample16=2000, sample48=0, period 64. busy=1, no smp_last.
//  2 cfg ftw=2048, phase0=16384, count=4; start -> 2000,1981,1924,1831; last on the 4th;
//    done pulses once; busy=0; cfg_ready=1.
//  3 Same burst with smp_ready low 5 cycles mid-burst -> smp_data stable, lut_t frozen,
//    exactly 4 samples, values unchanged.
//  4 Wrap: phase0=0xFC00, ftw=1024, count=3 -> 902,1000,1098. Index goes 63->0->1.
//  5 Continuous run, stop while a sample is held (smp_ready=0) -> held sample delivered,
//    no further samples, done pulse. cfg_valid during RUN is not accepted (cfg_ready=0).
//  6 rst_n low mid-burst -> smp_valid=0 at once; after release, cfg regs are at defaults and
//    test 1 output is repeated.

Source files
------------

// File: rtl/swg_pkg.sv
// Shared types and helpers for the sine-wave-generator phase sequencer.
// Holds the FSM state encoding, default tuning word and phase-to-index mapping.
package swg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } swg_state_e;

  localparam int LUT_DEPTH   = 64;
  localparam int PHASE_W_DEF = 16;
  localparam int IDX_W_DEF   = $clog2(LUT_DEPTH);

  // One LUT entry per sample: the step that advances the index by exactly one.
  function automatic logic [31:0] default_ftw(input int phase_w, input int idx_w);
    return 32'd1 << (phase_w - idx_w);
  endfunction

  localparam logic [PHASE_W_DEF-1:0] DEFAULT_FTW =
    PHASE_W_DEF'(default_ftw(PHASE_W_DEF, IDX_W_DEF));

  function automatic logic [31:0] phase_index(input logic [31:0] acc, input int phase_w,
                                              input int idx_w);
    return (acc >> (phase_w - idx_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/swg_phase_acc.sv
// Phase accumulator: load, advance by the tuning word, or hold.
// The top IDX_W bits of the accumulator address the sine LUT.
module swg_phase_acc
  import swg_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int IDX_W   = 6,
  parameter int T_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_load_val,
  input  logic               i_advance,
  input  logic [PHASE_W-1:0] i_ftw,
  output logic [T_W-1:0]     o_lut_t
);

  logic [PHASE_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_advance) begin
      r_acc <= r_acc + i_ftw;
    end
  end

  assign o_lut_t = T_W'(phase_index(32'(r_acc), PHASE_W, IDX_W));

endmodule

// File: rtl/swg_phase_ctrl.sv
// Sequencer for the sine LUT datapath: config handshake, burst/continuous runs,
// and a single-entry valid/ready output register toward the DAC formatter.
module swg_phase_ctrl
  import swg_pkg::*;
#(
  parameter int PHASE_W  = 16,
  parameter int IDX_W    = 6,
  parameter int T_W      = 10,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [PHASE_W-1:0]  i_cfg_ftw,
  input  logic [PHASE_W-1:0]  i_cfg_phase0,
  input  logic [CNT_W-1:0]    i_cfg_count,
  input  logic                i_start,
  input  logic                i_stop,
  output logic [T_W-1:0]      o_lut_t,
  input  logic [SAMPLE_W-1:0] i_lut_o,
  output logic                o_smp_valid,
  input  logic                i_smp_ready,
  output logic [SAMPLE_W-1:0] o_smp_data,
  output logic                o_smp_last,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [PHASE_W-1:0] FTW_RST = PHASE_W'(default_ftw(PHASE_W, IDX_W));

  swg_state_e          r_state;
  logic [PHASE_W-1:0]  r_ftw;
  logic [PHASE_W-1:0]  r_phase0;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_smp_valid;
  logic [SAMPLE_W-1:0] r_smp_data;
  logic                r_smp_last;
  logic                r_done;

  logic                w_cfg_ready;
  logic                w_cfg_fire;
  logic                w_start;
  logic                w_out_free;
  logic                w_issue;
  logic                w_last_issue;
  logic [PHASE_W-1:0]  w_load_phase;
  logic [CNT_W-1:0]    w_load_cnt;

  assign w_cfg_ready  = (r_state == IDLE);
  assign w_cfg_fire   = i_cfg_valid && w_cfg_ready;
  assign w_start      = (r_state == IDLE) && i_start;
  assign w_out_free   = !r_smp_valid || i_smp_ready;
  assign w_issue      = (r_state == RUN) && !i_stop && w_out_free;
  assign w_last_issue = w_issue && (r_cnt == CNT_W'(1));
  // A config offered in the same cycle as start takes effect for that run.
  assign w_load_phase = w_cfg_fire ? i_cfg_phase0 : r_phase0;
  assign w_load_cnt   = w_cfg_fire ? i_cfg_count : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ftw    <= FTW_RST;
      r_phase0 <= '0;
      r_count  <= '0;
    end else if (w_cfg_fire) begin
      r_ftw    <= i_cfg_ftw;
      r_phase0 <= i_cfg_phase0;
      r_count  <= i_cfg_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= RUN;
            r_cnt   <= w_load_cnt;
          end
        end
        RUN: begin
          if (i_stop) begin
            r_state <= FLUSH;
          end else if (w_issue) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            if (w_last_issue) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_out_free) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_valid <= 1'b0;
      r_smp_data  <= '0;
      r_smp_last  <= 1'b0;
    end else if (w_issue) begin
      r_smp_valid <= 1'b1;
      r_smp_data  <= i_lut_o;
      r_smp_last  <= w_last_issue;
    end else if (r_smp_valid && i_smp_ready) begin
      r_smp_valid <= 1'b0;
      r_smp_last  <= 1'b0;
    end
  end

  swg_phase_acc #(
    .PHASE_W (PHASE_W),
    .IDX_W   (IDX_W),
    .T_W     (T_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_load_val (w_load_phase),
    .i_advance  (w_issue),
    .i_ftw      (r_ftw),
    .o_lut_t    (o_lut_t)
  );

  assign o_cfg_ready = w_cfg_ready;
  assign o_smp_valid = r_smp_valid;
  assign o_smp_data  = r_smp_data;
  assign o_smp_last  = r_smp_last;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_swg_phase_ctrl.sv
// Directed bench for swg_phase_ctrl with a 64-entry sine LUT model
// (round(1000 + 1000*sin(2*pi*i/64))) on the LUT port.
module tb_swg_phase_ctrl;

  localparam int PHASE_W  = 16;
  localparam int IDX_W    = 6;
  localparam int T_W      = 10;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 16;

  logic                clk;
  logic                rst_n;
  logic                cfgValid;
  logic                cfgReady;
  logic [PHASE_W-1:0]  cfgFtw;
  logic [PHASE_W-1:0]  cfgPhase0;
  logic [CNT_W-1:0]    cfgCount;
  logic                start;
  logic                stop;
  logic [T_W-1:0]      lutT;
  logic [SAMPLE_W-1:0] lutO;
  logic                smpValid;
  logic                smpReady;
  logic [SAMPLE_W-1:0] smpData;
  logic                smpLast;
  logic                busy;
  logic                done;

  int checkCount = 0;
  int passCount  = 0;
  int doneCount  = 0;
  int sampleQ[$];
  int lastQ[$];
  int lutTable[64];

  swg_phase_ctrl #(
    .PHASE_W  (PHASE_W),
    .IDX_W    (IDX_W),
    .T_W      (T_W),
    .SAMPLE_W (SAMPLE_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_valid  (cfgValid),
    .o_cfg_ready  (cfgReady),
    .i_cfg_ftw    (cfgFtw),
    .i_cfg_phase0 (cfgPhase0),
    .i_cfg_count  (cfgCount),
    .i_start      (start),
    .i_stop       (stop),
    .o_lut_t      (lutT),
    .i_lut_o      (lutO),
    .o_smp_valid  (smpValid),
    .i_smp_ready  (smpReady),
    .o_smp_data   (smpData),
    .o_smp_last   (smpLast),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++)
      lutTable[i] = $rtoi(1000.0 + 1000.0 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5);
  end

  assign lutO = SAMPLE_W'(lutTable[lutT[5:0]]);

  // Records every accepted sample and every done pulse, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (smpValid && smpReady) begin
        sampleQ.push_back(int'(smpData));
        lastQ.push_back(int'(smpLast));
      end
      if (done) doneCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] ftw, input logic [15:0] ph,
                               input logic [15:0] cnt, input bit st, input bit sp,
                               input bit rdy);
    cfgValid  = v;
    cfgFtw    = ftw;
    cfgPhase0 = ph;
    cfgCount  = cnt;
    start     = st;
    stop      = sp;
    smpReady  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    sampleQ.delete();
    lastQ.delete();
    doneCount = 0;
  endtask

  task automatic waitSamples(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && sampleQ.size() < n; i++) tick();
    checkOutput(tag, 32'(sampleQ.size() >= n), 32'd1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  function automatic int lastSum();
    int s = 0;
    foreach (lastQ[i]) s += lastQ[i];
    return s;
  endfunction

  // Default config, ready=1: start, confirm latency, and check first four samples.
  task automatic defaultRun(input string tag, input int n);
    clearLog();
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_lat_valid"}, 32'(smpValid), 32'd0);
    tick();
    checkOutput({tag, "_first_valid"}, 32'(smpValid), 32'd1);
    checkOutput({tag, "_first_data"}, 32'(smpData), 32'd1000);
    waitSamples({tag, "_timeout"}, n, n + 20);
    checkOutput({tag, "_s0"}, 32'(sampleQ[0]), 32'd1000);
    checkOutput({tag, "_s1"}, 32'(sampleQ[1]), 32'd1098);
    checkOutput({tag, "_s2"}, 32'(sampleQ[2]), 32'd1195);
    checkOutput({tag, "_s3"}, 32'(sampleQ[3]), 32'd1290);
  endtask

  task automatic stopAndIdle(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    waitIdle({tag, "_idle"}, 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput({tag, "_done_once"}, 32'(doneCount), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_cfg_ready", 32'(cfgReady), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(smpValid), 32'd0);
    checkOutput("rst_data", 32'(smpData), 32'd0);
    checkOutput("rst_lut_t", 32'(lutT), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: default continuous run, one full period.
    defaultRun("t1", 65);
    checkOutput("t1_s16", 32'(sampleQ[16]), 32'd2000);
    checkOutput("t1_s48", 32'(sampleQ[48]), 32'd0);
    checkOutput("t1_s64", 32'(sampleQ[64]), 32'd1000);
    checkOutput("t1_nolast", 32'(lastSum()), 32'd0);
    stopAndIdle("t1");

    // Test 2: counted burst of 4.
    clearLog();
    applyStimulus(1, 2048, 16384, 4, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitIdle("t2_idle", 20);
    tick();
    checkOutput("t2_count", 32'(sampleQ.size()), 32'd4);
    checkOutput("t2_s0", 32'(sampleQ[0]), 32'd2000);
    checkOutput("t2_s1", 32'(sampleQ[1]), 32'd1981);
    checkOutput("t2_s2", 32'(sampleQ[2]), 32'd1924);
    checkOutput("t2_s3", 32'(sampleQ[3]), 32'd1831);
    checkOutput("t2_last3", 32'(lastQ[3]), 32'd1);
    checkOutput("t2_lastsum", 32'(lastSum()), 32'd1);
    checkOutput("t2_done", 32'(doneCount), 32'd1);
    checkOutput("t2_done_low", 32'(done), 32'd0);
    checkOutput("t2_cfg_ready", 32'(cfgReady), 32'd1);

    // Test 3: same burst with a 5-cycle backpressure stall after the second sample.
    clearLog();
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_valid", 32'(smpValid), 32'd1);
      checkOutput("t3_hold_data", 32'(smpData), 32'd1981);
      checkOutput("t3_hold_lut_t", 32'(lutT), 32'd20);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitIdle("t3_idle", 20);
    tick();
    checkOutput("t3_count", 32'(sampleQ.size()), 32'd4);
    checkOutput("t3_s0", 32'(sampleQ[0]), 32'd2000);
    checkOutput("t3_s1", 32'(sampleQ[1]), 32'd1981);
    checkOutput("t3_s2", 32'(sampleQ[2]), 32'd1924);
    checkOutput("t3_s3", 32'(sampleQ[3]), 32'd1831);
    checkOutput("t3_done", 32'(doneCount), 32'd1);

    // Test 4: phase wrap, config offered in the same cycle as start.
    clearLog();
    applyStimulus(1, 1024, 16'hFC00, 3, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t4_lut_t_start", 32'(lutT), 32'd63);
    waitIdle("t4_idle", 20);
    tick();
    checkOutput("t4_count", 32'(sampleQ.size()), 32'd3);
    checkOutput("t4_s0", 32'(sampleQ[0]), 32'd902);
    checkOutput("t4_s1", 32'(sampleQ[1]), 32'd1000);
    checkOutput("t4_s2", 32'(sampleQ[2]), 32'd1098);
    checkOutput("t4_last2", 32'(lastQ[2]), 32'd1);
    checkOutput("t4_lastsum", 32'(lastSum()), 32'd1);

    // Test 5: continuous run, stop while a sample is held; config offer during RUN refused.
    clearLog();
    applyStimulus(1, 1024, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    tick();
    applyStimulus(1, 4096, 16'h8000, 7, 0, 0, 0);
    checkOutput("t5_cfg_ready_run", 32'(cfgReady), 32'd0);
    tick();
    checkOutput("t5_held_data", 32'(smpData), 32'd1195);
    applyStimulus(1, 4096, 16'h8000, 7, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_flush_valid", 32'(smpValid), 32'd1);
      checkOutput("t5_flush_data", 32'(smpData), 32'd1195);
      checkOutput("t5_flush_busy", 32'(busy), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    waitIdle("t5_idle", 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("t5_count", 32'(sampleQ.size()), 32'd3);
    checkOutput("t5_s2", 32'(sampleQ[2]), 32'd1195);
    checkOutput("t5_done", 32'(doneCount), 32'd1);
    clearLog();
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitSamples("t5_rerun_timeout", 2, 20);
    checkOutput("t5_rerun_s0", 32'(sampleQ[0]), 32'd1000);
    checkOutput("t5_rerun_s1", 32'(sampleQ[1]), 32'd1098);
    stopAndIdle("t5_rerun");

    // Test 6: reset mid-burst, then config must be back at defaults.
    applyStimulus(1, 2048, 0, 8, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", 32'(smpValid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_cfg_ready", 32'(cfgReady), 32'd1);
    checkOutput("t6_lut_t", 32'(lutT), 32'd0);
    checkOutput("t6_data", 32'(smpData), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    defaultRun("t6", 4);
    checkOutput("t6_nolast", 32'(lastSum()), 32'd0);
    stopAndIdle("t6");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
